// File: rtl/instr_fetch_buffer_pkg.sv
// Shared types for the instruction fetch buffer: FSM states and FIFO entry.
package instr_fetch_buffer_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FLUSH
    } fetch_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_buffer_if.sv
// Fetch-side bundle: PC unit, instruction memory and decode handshake.
interface instr_fetch_buffer_if;
    import instr_fetch_buffer_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] pc;
    logic              pc_adv;
    logic              flush;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;

    modport master (
        output start, pc, flush, imem_rdata, instr_ready,
        input  pc_adv, imem_req, imem_addr, instr, instr_pc, instr_valid
    );

    modport slave (
        input  start, pc, flush, imem_rdata, instr_ready,
        output pc_adv, imem_req, imem_addr, instr, instr_pc, instr_valid
    );

endinterface

// File: rtl/instr_fetch_buffer_fifo.sv
// Synchronous FIFO of tagged fetch entries; clear empties it in one cycle.
module instr_fetch_buffer_fifo
    import instr_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   clear_i,
    input  fetch_entry_t           data_i,
    output fetch_entry_t           data_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t   mem_q [DEPTH];
    logic [PW-1:0]  wr_q, wr_d;
    logic [PW-1:0]  rd_q, rd_d;
    logic [PW:0]    count_q, count_d;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (clear_i) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + PW'(1);
            if (pop_i)  rd_d = rd_q + PW'(1);
            count_d = count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch buffer top: request FSM, one-deep read credit, PC tagging, decode FIFO.
module instr_fetch_buffer
    import instr_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic                 clk,
    input logic                 reset,
    instr_fetch_buffer_if.slave bus
);

    localparam int PW = $clog2(DEPTH);

    fetch_state_t      state_q, state_d;
    logic              inflight_q, inflight_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PW:0]       count;
    logic [PW+1:0]     credit;
    logic              req, push, pop, valid;
    fetch_entry_t      head, wdata;

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = FLUSH;
        end else begin
            unique case (state_q)
                IDLE:    state_d = bus.start ? FETCH : IDLE;
                FETCH:   state_d = bus.start ? FETCH : IDLE;
                FLUSH:   state_d = bus.start ? FETCH : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Buffered plus outstanding words never exceed DEPTH, so a push always fits.
    always_comb begin
        credit     = {1'b0, count} + (PW+2)'(inflight_q);
        req        = (state_q == FETCH) && bus.start && !bus.flush
                     && (credit < (PW+2)'(DEPTH));
        inflight_d = req;
        drop_d     = bus.flush && inflight_q;
        pc_d       = req ? bus.pc : pc_q;
        push       = inflight_q && !drop_q && !bus.flush;
        valid      = (count != '0);
        pop        = valid && bus.instr_ready && !bus.flush;
        wdata      = '{instr: bus.imem_rdata, pc: pc_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
            pc_q       <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            pc_q       <= pc_d;
        end
    end

    instr_fetch_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (bus.flush),
        .data_i  (wdata),
        .data_o  (head),
        .count_o (count)
    );

    assign bus.imem_req    = req;
    assign bus.pc_adv      = req;
    assign bus.imem_addr   = req ? bus.pc : '0;
    assign bus.instr_valid = valid;
    assign bus.instr       = valid ? head.instr : '0;
    assign bus.instr_pc    = valid ? head.pc : '0;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: cycle vectors plus a fetch scoreboard.
module tb_instr_fetch_buffer;
    import instr_fetch_buffer_pkg::*;

    typedef struct {
        logic        start;
        logic        ready;
        logic        req;
        logic        valid;
        logic [31:0] addr;
        logic [31:0] ipc;
        logic [31:0] ins;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    instr_fetch_buffer_if bus ();

    instr_fetch_buffer #(.DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous instruction memory: word = 0xE000_0000 + address.
    always @(posedge clk) begin
        bus.imem_rdata <= bus.imem_req ? 32'hE000_0000 + bus.imem_addr
                                       : 32'hDEAD_BEEF;
    end

    int           n_chk;
    int           n_pass;
    int           n_req;
    int           n_pop;
    logic [31:0]  first_pc;
    logic [31:0]  pc_v;
    fetch_entry_t sb [$];
    vec_t         tbl [6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic step();
        fetch_entry_t e;
        logic adv;
        adv = 1'b0;
        if (bus.instr_valid && bus.instr_ready && !bus.flush && !reset) begin
            if (n_pop == 0) first_pc = bus.instr_pc;
            n_pop++;
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL stale_pop actual=%h expected=none", bus.instr_pc);
            end else begin
                e = sb.pop_front();
                chk("pop_pc", bus.instr_pc, e.pc);
                chk("pop_instr", bus.instr, e.instr);
            end
        end
        if (reset || bus.flush) sb.delete();
        if (bus.imem_req && !reset) begin
            n_req++;
            chk("imem_addr", bus.imem_addr, pc_v);
            chk1("pc_adv", bus.pc_adv, 1'b1);
            sb.push_back('{instr: 32'hE000_0000 + pc_v, pc: pc_v});
            adv = bus.pc_adv;
        end
        @(negedge clk);
        if (adv) pc_v = pc_v + 32'd4;
        bus.pc = pc_v;
    endtask

    task automatic tick();
        #1;
        step();
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.flush       = 1'b0;
        bus.instr_ready = 1'b0;
        tick();
        tick();
        reset  = 1'b0;
        pc_v   = 32'h0;
        bus.pc = pc_v;
    endtask

    initial begin
        int r0;
        n_chk = 0;
        n_pass = 0;
        n_req = 0;
        n_pop = 0;
        first_pc = '0;
        pc_v = '0;
        reset = 1'b1;
        bus.pc = '0;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.instr_ready = 1'b0;

        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0, 32'h0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0, 32'h0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h4,  32'h0, 32'h0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h8,  32'h0, 32'hE000_0000};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hC,  32'h4, 32'hE000_0004};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 32'h8, 32'hE000_0008};

        @(negedge clk);
        do_reset();

        // Steady stream from reset: row 0 is the first cycle after reset.
        for (int i = 0; i < 6; i++) begin
            bus.start = tbl[i].start;
            bus.instr_ready = tbl[i].ready;
            #1;
            chk1("v_req", bus.imem_req, tbl[i].req);
            chk1("v_adv", bus.pc_adv, tbl[i].req);
            chk("v_addr", bus.imem_addr, tbl[i].addr);
            chk1("v_valid", bus.instr_valid, tbl[i].valid);
            chk("v_ipc", bus.instr_pc, tbl[i].ipc);
            chk("v_instr", bus.instr, tbl[i].ins);
            step();
        end

        // One stalled cycle lifts count to 2, then push+pop holds it across wrap.
        bus.instr_ready = 1'b0;
        tick();
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            chk("pp_count", 32'(dut.count), 32'd2);
            step();
        end

        // start falls with one read outstanding.
        bus.start = 1'b0;
        r0 = n_req;
        for (int i = 0; i < 6; i++) tick();
        chk("stop_reqs", 32'(n_req - r0), 32'd0);
        chk("stop_drained", 32'(sb.size()), 32'd0);
        chk("stop_state", 32'(dut.state_q), 32'(IDLE));

        // Backpressure: exactly DEPTH requests, then drain and resume.
        do_reset();
        bus.start = 1'b1;
        r0 = n_req;
        for (int i = 0; i < 8; i++) tick();
        chk("bp_reqs", 32'(n_req - r0), 32'd4);
        #1;
        chk1("bp_adv", bus.pc_adv, 1'b0);
        chk("bp_count", 32'(dut.count), 32'd4);
        step();
        bus.instr_ready = 1'b1;
        n_pop = 0;
        for (int i = 0; i < 12; i++) tick();
        chk("bp_first", first_pc, 32'h0);

        // Branch flush with 3 buffered and 1 in flight.
        do_reset();
        bus.start = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        #1;
        chk("fl_count", 32'(dut.count), 32'd3);
        step();
        bus.flush = 1'b1;
        bus.instr_ready = 1'b1;
        pc_v = 32'h100;
        bus.pc = pc_v;
        tick();
        bus.flush = 1'b0;
        #1;
        chk1("fl_valid", bus.instr_valid, 1'b0);
        chk1("fl_req", bus.imem_req, 1'b0);
        step();
        n_pop = 0;
        for (int i = 0; i < 8; i++) tick();
        chk("fl_first_pc", first_pc, 32'h100);

        // Reset mid-stream with 2 buffered and 1 in flight.
        do_reset();
        bus.start = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pc_v = 32'h0;
        bus.pc = pc_v;
        #1;
        chk1("rs_req", bus.imem_req, 1'b0);
        chk1("rs_adv", bus.pc_adv, 1'b0);
        chk("rs_addr", bus.imem_addr, 32'h0);
        chk1("rs_valid", bus.instr_valid, 1'b0);
        chk("rs_instr", bus.instr, 32'h0);
        chk("rs_ipc", bus.instr_pc, 32'h0);
        chk("rs_count", 32'(dut.count), 32'd0);
        step();
        bus.instr_ready = 1'b1;
        n_pop = 0;
        for (int i = 0; i < 8; i++) tick();
        chk("rs_first_pc", first_pc, 32'h0);

        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
